// File: rtl/out_port_arbiter.sv
// Output-port allocator for a 3-input NoC router slice: wormhole-locked grant of S/W/L FIFOs.
// Optional feature macro: PRESSURE_PRIO_EN (congestion-aware grant selection in IDLE).
module out_port_arbiter #(
   parameter int DATASIZE     = 40,
   parameter int WIDTH        = 3,
   parameter int PRESS_THRESH = 6
) (
   input  logic                fifo_clk,
   input  logic                rst_n,
   input  logic [DATASIZE-1:0] S_data_in,
   input  logic [DATASIZE-1:0] W_data_in,
   input  logic [DATASIZE-1:0] L_data_in,
   input  logic                S_valid_in,
   input  logic                W_valid_in,
   input  logic                L_valid_in,
   input  logic                S_req_in,
   input  logic                W_req_in,
   input  logic                L_req_in,
   input  logic [WIDTH:0]      S_pressure_in,
   input  logic [WIDTH:0]      W_pressure_in,
   input  logic [WIDTH:0]      L_pressure_in,
   output logic                fifo_ready_S,
   output logic                fifo_ready_W,
   output logic                fifo_ready_L,
   output logic [DATASIZE-1:0] out_data,
   output logic                out_valid,
   input  logic                out_full_in,
   output logic [2:0]          grant_onehot,
   output logic                pkt_done
);

   typedef enum logic {IDLE, LOCK} state_t;

   state_t              state, state_nxt;
   logic [1:0]          gidx, gidx_nxt;
   logic [1:0]          rr_ptr, rr_nxt;
   logic [DATASIZE-1:0] data_a [3];
   logic [2:0]          valid_a, req_a, cand, ready, gnt_oh;
   logic [1:0]          pick, idx;
   logic                found;
   logic                slot_free, pop;
   logic [DATASIZE-1:0] pop_data;

   assign data_a[0] = S_data_in;
   assign data_a[1] = W_data_in;
   assign data_a[2] = L_data_in;
   assign valid_a   = {L_valid_in, W_valid_in, S_valid_in};
   assign req_a     = {L_req_in, W_req_in, S_req_in};

   // Head (10) and single (11) both have the MSB of the type field set.
   always_comb begin
      cand = '0;
      for (int unsigned i = 0; i < 3; i++)
         cand[i] = valid_a[i] & req_a[i] & data_a[i][DATASIZE-1];
   end

   function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] off);
      logic [2:0] s;
      s = {1'b0, base} + {1'b0, off};
      if (s >= 3'd3) s = s - 3'd3;
      return s[1:0];
   endfunction

`ifdef PRESSURE_PRIO_EN
   localparam logic [WIDTH:0] THRESH = (WIDTH+1)'(PRESS_THRESH);
   logic [WIDTH:0] press_a [3];
   logic [WIDTH:0] best;
   logic [2:0]     hot;

   assign press_a[0] = S_pressure_in;
   assign press_a[1] = W_pressure_in;
   assign press_a[2] = L_pressure_in;

   // Strict '>' while scanning in rr order keeps the earliest rr candidate on ties.
   always_comb begin
      hot = '0;
      for (int unsigned i = 0; i < 3; i++)
         hot[i] = cand[i] & (press_a[i] >= THRESH);
      pick  = '0;
      found = 1'b0;
      best  = '0;
      idx   = '0;
      for (int unsigned i = 0; i < 3; i++) begin
         idx = rr_idx(rr_ptr, 2'(i));
         if (|hot) begin
            if (hot[idx] && (!found || press_a[idx] > best)) begin
               pick  = idx;
               found = 1'b1;
               best  = press_a[idx];
            end
         end else if (cand[idx] && !found) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end
`else
   logic unused_press;
   assign unused_press = ^{S_pressure_in, W_pressure_in, L_pressure_in};

   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < 3; i++) begin
         idx = rr_idx(rr_ptr, 2'(i));
         if (cand[idx] && !found) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end
`endif

   assign gnt_oh       = 3'b001 << gidx;
   assign grant_onehot = (state == LOCK) ? gnt_oh : '0;
   assign slot_free    = !out_valid || !out_full_in;
   assign ready        = (rst_n && state == LOCK && slot_free) ? (gnt_oh & valid_a) : '0;
   assign fifo_ready_S = ready[0];
   assign fifo_ready_W = ready[1];
   assign fifo_ready_L = ready[2];
   assign pop          = |ready;
   assign pop_data     = data_a[gidx];
   assign pkt_done     = pop & pop_data[DATASIZE-2];

   always_comb begin
      state_nxt = state;
      gidx_nxt  = gidx;
      rr_nxt    = rr_ptr;
      case (state)
         IDLE: begin
            if (|cand) begin
               state_nxt = LOCK;
               gidx_nxt  = pick;
            end
         end
         LOCK: begin
            if (pkt_done) begin
               state_nxt = IDLE;
               rr_nxt    = (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge fifo_clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         gidx      <= '0;
         rr_ptr    <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         state  <= state_nxt;
         gidx   <= gidx_nxt;
         rr_ptr <= rr_nxt;
         if (pop) begin
            out_data  <= pop_data;
            out_valid <= 1'b1;
         end else if (slot_free) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_out_port_arbiter.sv
// Directed self-checking bench for out_port_arbiter with behavioural source FIFOs and a sink log.
module tb_out_port_arbiter;

   localparam logic [1:0] BODY = 2'b00, TAIL = 2'b01, HEAD = 2'b10, SGL = 2'b11;

   logic        fifo_clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [39:0] S_data_in = '0, W_data_in = '0, L_data_in = '0;
   logic        S_valid_in = 1'b0, W_valid_in = 1'b0, L_valid_in = 1'b0;
   logic        S_req_in = 1'b0, W_req_in = 1'b0, L_req_in = 1'b0;
   logic [3:0]  S_pressure_in = '0, W_pressure_in = '0, L_pressure_in = '0;
   logic        fifo_ready_S, fifo_ready_W, fifo_ready_L;
   logic [39:0] out_data;
   logic        out_valid;
   logic        out_full_in = 1'b0;
   logic [2:0]  grant_onehot;
   logic        pkt_done;

   logic [39:0] sq[$], wq[$], lq[$], rx[$];
   logic [2:0]  glog[$];
   int          pop_cyc[$];
   int          pkt_cnt = 0, cyc = 0, checks = 0, fails = 0;
   logic        pop_s = 1'b0, pop_w = 1'b0, pop_l = 1'b0;
   logic [2:0]  prev_grant = '0;

   out_port_arbiter #(.DATASIZE(40), .WIDTH(3), .PRESS_THRESH(6)) dut (
      .fifo_clk(fifo_clk), .rst_n(rst_n),
      .S_data_in(S_data_in), .W_data_in(W_data_in), .L_data_in(L_data_in),
      .S_valid_in(S_valid_in), .W_valid_in(W_valid_in), .L_valid_in(L_valid_in),
      .S_req_in(S_req_in), .W_req_in(W_req_in), .L_req_in(L_req_in),
      .S_pressure_in(S_pressure_in), .W_pressure_in(W_pressure_in), .L_pressure_in(L_pressure_in),
      .fifo_ready_S(fifo_ready_S), .fifo_ready_W(fifo_ready_W), .fifo_ready_L(fifo_ready_L),
      .out_data(out_data), .out_valid(out_valid), .out_full_in(out_full_in),
      .grant_onehot(grant_onehot), .pkt_done(pkt_done)
   );

   always #5 fifo_clk = ~fifo_clk;

   function automatic logic [39:0] mk(input logic [1:0] t, input logic [37:0] p);
      return {t, p};
   endfunction

   // Source FIFOs: pop on the edge after a ready was seen, present new heads 1 time unit later.
   always @(posedge fifo_clk) begin
      cyc++;
      if (pop_s && sq.size() > 0) void'(sq.pop_front());
      if (pop_w && wq.size() > 0) void'(wq.pop_front());
      if (pop_l && lq.size() > 0) void'(lq.pop_front());
      #1;
      S_valid_in = sq.size() > 0; S_req_in = S_valid_in; S_data_in = S_valid_in ? sq[0] : '0;
      W_valid_in = wq.size() > 0; W_req_in = W_valid_in; W_data_in = W_valid_in ? wq[0] : '0;
      L_valid_in = lq.size() > 0; L_req_in = L_valid_in; L_data_in = L_valid_in ? lq[0] : '0;
   end

   always @(negedge fifo_clk) begin
      pop_s = fifo_ready_S; pop_w = fifo_ready_W; pop_l = fifo_ready_L;
      if (out_valid && !out_full_in) rx.push_back(out_data);
      if (pkt_done) pkt_cnt++;
      if (fifo_ready_S || fifo_ready_W || fifo_ready_L) pop_cyc.push_back(cyc);
      if (grant_onehot != 3'b000 && prev_grant == 3'b000) glog.push_back(grant_onehot);
      prev_grant = grant_onehot;
      checks++;
      if ($countones({fifo_ready_L, fifo_ready_W, fifo_ready_S}) > 1 ||
          ({fifo_ready_L, fifo_ready_W, fifo_ready_S} & ~grant_onehot) !== 3'b000) begin
         fails++;
         $display("FAIL ready_invariant ready=%b grant=%b (need <=1 ready, inside grant)",
                  {fifo_ready_L, fifo_ready_W, fifo_ready_S}, grant_onehot);
      end
   end

   task automatic tick();
      @(posedge fifo_clk); #2;
   endtask

   task automatic clear_logs();
      rx.delete(); glog.delete(); pop_cyc.delete(); pkt_cnt = 0;
   endtask

   task automatic wait_rx(input int n, input int budget, output bit ok);
      for (int i = 0; i < budget; i++) begin
         if (rx.size() >= n) break;
         tick();
      end
      ok = rx.size() >= n;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      sq.push_back(mk(SGL, 38'h1)); wq.push_back(mk(SGL, 38'h2)); lq.push_back(mk(SGL, 38'h3));
      repeat (3) tick();
      checks++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++;
      if (grant_onehot !== 3'b000) begin fails++; $display("FAIL reset_grant got=%b exp=000", grant_onehot); end
      checks++;
      if ({fifo_ready_L, fifo_ready_W, fifo_ready_S} !== 3'b000) begin
         fails++; $display("FAIL reset_ready got=%b exp=000", {fifo_ready_L, fifo_ready_W, fifo_ready_S});
      end
      checks++;
      if (out_data !== 40'h0 || pkt_done !== 1'b0) begin
         fails++; $display("FAIL reset_data got=%h/%b exp=0/0", out_data, pkt_done);
      end
      sq.delete(); wq.delete(); lq.delete();
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      logic [39:0] exp [3];
      logic [2:0]  eg [3];
      bit ok;
      clear_logs();
      exp[0] = mk(SGL, 38'h101); exp[1] = mk(SGL, 38'h102); exp[2] = mk(SGL, 38'h103);
      eg[0] = 3'b001; eg[1] = 3'b010; eg[2] = 3'b100;
      sq.push_back(exp[0]); wq.push_back(exp[1]); lq.push_back(exp[2]);
      wait_rx(3, 40, ok);
      checks++;
      if (!ok) begin fails++; $display("FAIL single_timeout got=%0d exp=3 flits", rx.size()); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (rx[i] !== exp[i]) begin fails++; $display("FAIL single_data[%0d] got=%h exp=%h", i, rx[i], exp[i]); end
         checks++;
         if (glog[i] !== eg[i]) begin fails++; $display("FAIL single_grant[%0d] got=%b exp=%b", i, glog[i], eg[i]); end
      end
      checks++;
      if (pkt_cnt != 3) begin fails++; $display("FAIL single_pkt_done got=%0d exp=3", pkt_cnt); end
      checks++;
      if (pop_cyc[2] - pop_cyc[0] != 4) begin
         fails++; $display("FAIL single_spacing got=%0d exp=4 cycles", pop_cyc[2] - pop_cyc[0]);
      end
      repeat (2) tick();
   endtask

   task automatic test_wormhole();
      logic [39:0] exp [7];
      bit ok;
      clear_logs();
      exp[0] = mk(HEAD, 38'h11); exp[1] = mk(BODY, 38'h12); exp[2] = mk(BODY, 38'h13);
      exp[3] = mk(BODY, 38'h14); exp[4] = mk(TAIL, 38'h15);
      exp[5] = mk(HEAD, 38'h21); exp[6] = mk(TAIL, 38'h22);
      for (int i = 0; i < 5; i++) sq.push_back(exp[i]);
      wq.push_back(exp[5]); wq.push_back(exp[6]);
      wait_rx(7, 60, ok);
      checks++;
      if (!ok) begin fails++; $display("FAIL worm_timeout got=%0d exp=7 flits", rx.size()); end
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (rx[i] !== exp[i]) begin fails++; $display("FAIL worm_data[%0d] got=%h exp=%h", i, rx[i], exp[i]); end
      end
      checks++;
      if (glog.size() != 2 || glog[0] !== 3'b001 || glog[1] !== 3'b010) begin
         fails++; $display("FAIL worm_grants got=%0d:%b,%b exp=2:001,010", glog.size(), glog[0], glog[1]);
      end
      checks++;
      if (pop_cyc[4] - pop_cyc[0] != 4 || pop_cyc[5] - pop_cyc[4] != 2) begin
         fails++; $display("FAIL worm_timing got=%0d,%0d exp=4,2",
                           pop_cyc[4] - pop_cyc[0], pop_cyc[5] - pop_cyc[4]);
      end
      checks++;
      if (pkt_cnt != 2) begin fails++; $display("FAIL worm_pkt_done got=%0d exp=2", pkt_cnt); end
      repeat (2) tick();
   endtask

   task automatic test_backpressure();
      logic [39:0] exp [7];
      logic [39:0] held;
      bit ok;
      clear_logs();
      exp[0] = mk(HEAD, 38'h30); exp[6] = mk(TAIL, 38'h36);
      for (int i = 1; i < 6; i++) exp[i] = mk(BODY, 38'h30 + 38'(i));
      for (int i = 0; i < 7; i++) sq.push_back(exp[i]);
      wait_rx(2, 30, ok);
      out_full_in = 1'b1;
      held = out_data;
      #1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (out_data !== held || out_valid !== 1'b1 || fifo_ready_S !== 1'b0) begin
            fails++; $display("FAIL bp_stall[%0d] got=%h/%b/%b exp=%h/1/0", i, out_data, out_valid, fifo_ready_S, held);
         end
         if (i < 3) tick();
      end
      tick();
      out_full_in = 1'b0;
      wait_rx(7, 40, ok);
      checks++;
      if (!ok || rx.size() != 7) begin fails++; $display("FAIL bp_count got=%0d exp=7", rx.size()); end
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (rx[i] !== exp[i]) begin fails++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, rx[i], exp[i]); end
      end
      repeat (3) tick();
      checks++;
      if (rx.size() != 7) begin fails++; $display("FAIL bp_dup got=%0d exp=7", rx.size()); end
   endtask

   task automatic test_orphan_body();
      clear_logs();
      wq.push_back(mk(BODY, 38'h77));
      repeat (6) tick();
      checks++;
      if (glog.size() != 0 || pop_cyc.size() != 0 || grant_onehot !== 3'b000) begin
         fails++; $display("FAIL orphan_body got=%0d grants,%0d pops exp=0,0", glog.size(), pop_cyc.size());
      end
      wq.delete();
      repeat (2) tick();
   endtask

   task automatic test_fairness();
      int cnt [3];
      bit ok;
      clear_logs();
      cnt[0] = 0; cnt[1] = 0; cnt[2] = 0;
      for (int i = 0; i < 10; i++) begin
         sq.push_back(mk(SGL, 38'h400 + 38'(i)));
         wq.push_back(mk(SGL, 38'h500 + 38'(i)));
         lq.push_back(mk(SGL, 38'h600 + 38'(i)));
      end
      wait_rx(30, 200, ok);
      checks++;
      if (!ok) begin fails++; $display("FAIL fair_timeout got=%0d exp=30 flits", rx.size()); end
      for (int i = 0; i < glog.size(); i++) begin
         if (glog[i] == 3'b001) cnt[0]++;
         if (glog[i] == 3'b010) cnt[1]++;
         if (glog[i] == 3'b100) cnt[2]++;
      end
      checks++;
      if (cnt[0] != 10 || cnt[1] != 10 || cnt[2] != 10) begin
         fails++; $display("FAIL fair_counts got=%0d/%0d/%0d exp=10/10/10", cnt[0], cnt[1], cnt[2]);
      end
      checks++;
      if (glog[0] !== 3'b010 || glog[1] !== 3'b100 || glog[2] !== 3'b001) begin
         fails++; $display("FAIL fair_order got=%b,%b,%b exp=010,100,001", glog[0], glog[1], glog[2]);
      end
      repeat (2) tick();
   endtask

   task automatic test_pressure();
      logic [2:0] exp_first;
      bit ok;
`ifdef PRESSURE_PRIO_EN
      exp_first = 3'b100;
`else
      exp_first = 3'b001;
`endif
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      clear_logs();
      S_pressure_in = 4'd2; L_pressure_in = 4'd7;
      sq.push_back(mk(SGL, 38'h801)); lq.push_back(mk(SGL, 38'h803));
      wait_rx(2, 30, ok);
      checks++;
      if (!ok || glog[0] !== exp_first) begin fails++; $display("FAIL press_first got=%b exp=%b", glog[0], exp_first); end
      checks++;
      if (glog[1] !== (exp_first ^ 3'b101)) begin
         fails++; $display("FAIL press_second got=%b exp=%b", glog[1], exp_first ^ 3'b101);
      end
      S_pressure_in = '0; L_pressure_in = '0;
      repeat (2) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_wormhole();
      test_backpressure();
      test_orphan_body();
      test_fairness();
      test_pressure();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
